// File: rtl/tcp_option_pkg.sv
// Shared TCP option constants, FSM state type and the plan record.
// Also used by output_shift_byte_counter on the RX side.
package tcp_option_pkg;

    localparam logic [7:0] KIND_EOL   = 8'd0;
    localparam logic [7:0] KIND_NOP   = 8'd1;
    localparam logic [7:0] KIND_MSS   = 8'd2;
    localparam logic [7:0] KIND_WS    = 8'd3;
    localparam logic [7:0] KIND_SACKP = 8'd4;
    localparam logic [7:0] KIND_SACK  = 8'd5;
    localparam logic [7:0] KIND_TS    = 8'd8;

    localparam logic [7:0] LEN_MSS        = 8'd4;
    localparam logic [7:0] LEN_WS         = 8'd3;
    localparam logic [7:0] LEN_SACKP      = 8'd2;
    localparam logic [7:0] LEN_TS         = 8'd10;
    localparam logic [7:0] LEN_SACK_BASE  = 8'd2;
    localparam logic [7:0] LEN_SACK_BLOCK = 8'd8;

    localparam int OPT_SPACE_BYTES = 40;
    localparam int SACK_BLOCKS_MAX = 4;
    localparam int OPT_MAX_WORDS   = OPT_SPACE_BYTES / 4;

    // Kinds this encoder knows how to emit: 2, 3, 4, 5 and 8.
    localparam logic [8:0] LEGAL_KINDS = 9'b1_0011_1100;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FIN
    } enc_state_t;

    typedef struct packed {
        logic       mss_on;
        logic       ws_on;
        logic       sackp_on;
        logic       ts_on;
        logic [2:0] sack_blocks;
        logic [3:0] opt_words;
        logic [8:0] err;
    } opt_plan_t;

    function automatic logic [7:0] sack_len(input logic [2:0] blocks);
        return LEN_SACK_BASE + LEN_SACK_BLOCK * {5'd0, blocks};
    endfunction

endpackage

// File: rtl/tcp_option_planner.sv
// Combinational option planner: decides which options are emitted, trims the
// SACK block count to the option-space budget and flags per-kind errors.
module tcp_option_planner
    import tcp_option_pkg::*;
#(
    parameter int MAX_BYTES  = OPT_SPACE_BYTES,
    parameter int SACK_LIMIT = SACK_BLOCKS_MAX
) (
    input  logic [8:0] option_en,
    input  logic [2:0] sack_nbr,
    output opt_plan_t  plan
);

    logic [7:0] used_bytes;
    logic [7:0] room;
    logic [7:0] fit_blocks;
    logic [7:0] req_blocks;

    // Every non-SACK option occupies whole words, so SACK gets whatever is left.
    always_comb begin
        plan          = '0;
        plan.mss_on   = option_en[2];
        plan.ws_on    = option_en[3];
        plan.sackp_on = option_en[4];
        plan.ts_on    = option_en[8];

        used_bytes = (option_en[2] ? 8'd4  : 8'd0)
                   + (option_en[3] ? 8'd4  : 8'd0)
                   + (option_en[4] ? 8'd4  : 8'd0)
                   + (option_en[8] ? 8'd12 : 8'd0);
        room       = (used_bytes < 8'(MAX_BYTES)) ? 8'(MAX_BYTES) - used_bytes : 8'd0;
        fit_blocks = (room >= 8'd4) ? ((room - 8'd4) >> 3) : 8'd0;
        if (fit_blocks > 8'(SACK_LIMIT)) begin
            fit_blocks = 8'(SACK_LIMIT);
        end
        req_blocks = {5'd0, sack_nbr};

        if (option_en[5]) begin
            if (req_blocks == 8'd0 || req_blocks > 8'(SACK_LIMIT)) begin
                plan.err[5] = 1'b1;
            end else if (req_blocks > fit_blocks) begin
                plan.sack_blocks = fit_blocks[2:0];
                plan.err[5]      = 1'b1;
            end else begin
                plan.sack_blocks = sack_nbr;
            end
        end

        plan.err       = plan.err | (option_en & ~LEGAL_KINDS);
        plan.opt_words = 4'(used_bytes >> 2)
                       + ((plan.sack_blocks != 3'd0) ? (4'd1 + {plan.sack_blocks, 1'b0}) : 4'd0);
    end

endmodule

// File: rtl/tcp_option_encoder.sv
// TX TCP option serializer: latches option values at start and streams the
// NOP-padded option field as 32-bit words over a valid/ready handshake.
module tcp_option_encoder
    import tcp_option_pkg::*;
#(
    parameter int MAX_OPT_BYTES = OPT_SPACE_BYTES,
    parameter int MAX_SACK      = SACK_BLOCKS_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  option_en,
    input  logic [15:0] mss,
    input  logic [7:0]  scale_wnd,
    input  logic [2:0]  sack_nbr,
    input  logic [63:0] sack_n0,
    input  logic [63:0] sack_n1,
    input  logic [63:0] sack_n2,
    input  logic [63:0] sack_n3,
    input  logic [63:0] time_stp,
    input  logic        data_ready,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        data_last,
    output logic        busy,
    output logic        done,
    output logic [3:0]  opt_words,
    output logic [8:0]  option_err
);

    enc_state_t  state, state_next;
    opt_plan_t   plan_now, plan_q;

    logic [15:0] mss_q;
    logic [7:0]  scale_q;
    logic [63:0] sack_q0, sack_q1, sack_q2, sack_q3;
    logic [63:0] ts_q;
    logic [3:0]  word_idx;

    logic        accept_start, load_first, advance, finish;
    logic [31:0] word_list [16];
    logic [63:0] sack_blk  [4];
    logic [3:0]  ptr;

    tcp_option_planner #(
        .MAX_BYTES (MAX_OPT_BYTES),
        .SACK_LIMIT(MAX_SACK)
    ) u_planner (
        .option_en(option_en),
        .sack_nbr (sack_nbr),
        .plan     (plan_now)
    );

    // Lay the planned options out back to back in emission order.
    always_comb begin
        word_list   = '{default: '0};
        sack_blk[0] = sack_q0;
        sack_blk[1] = sack_q1;
        sack_blk[2] = sack_q2;
        sack_blk[3] = sack_q3;
        ptr         = 4'd0;
        if (plan_q.mss_on) begin
            word_list[ptr] = {KIND_MSS, LEN_MSS, mss_q};
            ptr = ptr + 4'd1;
        end
        if (plan_q.ws_on) begin
            word_list[ptr] = {KIND_NOP, KIND_WS, LEN_WS, scale_q};
            ptr = ptr + 4'd1;
        end
        if (plan_q.sackp_on) begin
            word_list[ptr] = {KIND_NOP, KIND_NOP, KIND_SACKP, LEN_SACKP};
            ptr = ptr + 4'd1;
        end
        if (plan_q.ts_on) begin
            word_list[ptr]        = {KIND_NOP, KIND_NOP, KIND_TS, LEN_TS};
            word_list[ptr + 4'd1] = ts_q[63:32];
            word_list[ptr + 4'd2] = ts_q[31:0];
            ptr = ptr + 4'd3;
        end
        if (plan_q.sack_blocks != 3'd0) begin
            word_list[ptr] = {KIND_NOP, KIND_NOP, KIND_SACK, sack_len(plan_q.sack_blocks)};
            ptr = ptr + 4'd1;
            for (int b = 0; b < 4; b++) begin
                if (3'(b) < plan_q.sack_blocks) begin
                    word_list[ptr]        = sack_blk[b][63:32];
                    word_list[ptr + 4'd1] = sack_blk[b][31:0];
                    ptr = ptr + 4'd2;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The first EMIT cycle only primes the output register from the latched plan.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        load_first   = 1'b0;
        advance      = 1'b0;
        finish       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = (plan_now.opt_words == 4'd0) ? FIN : EMIT;
                end
            end
            EMIT: begin
                if (!data_valid) begin
                    load_first = 1'b1;
                end else if (data_ready) begin
                    if (word_idx == opt_words) begin
                        finish     = 1'b1;
                        state_next = FIN;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            plan_q     <= '0;
            mss_q      <= '0;
            scale_q    <= '0;
            sack_q0    <= '0;
            sack_q1    <= '0;
            sack_q2    <= '0;
            sack_q3    <= '0;
            ts_q       <= '0;
            word_idx   <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            opt_words  <= '0;
            option_err <= '0;
        end else begin
            done <= (state == FIN);
            if (accept_start) begin
                plan_q     <= plan_now;
                mss_q      <= mss;
                scale_q    <= scale_wnd;
                sack_q0    <= sack_n0;
                sack_q1    <= sack_n1;
                sack_q2    <= sack_n2;
                sack_q3    <= sack_n3;
                ts_q       <= time_stp;
                word_idx   <= '0;
                data_valid <= 1'b0;
                data_last  <= 1'b0;
                busy       <= (plan_now.opt_words != 4'd0);
                opt_words  <= plan_now.opt_words;
                option_err <= plan_now.err;
            end else if (load_first || advance) begin
                data       <= word_list[word_idx];
                data_valid <= 1'b1;
                data_last  <= ((word_idx + 4'd1) == opt_words);
                word_idx   <= word_idx + 4'd1;
            end else if (finish) begin
                data_valid <= 1'b0;
                data_last  <= 1'b0;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tcp_option_encoder.sv
// Self-checking bench for tcp_option_encoder: directed cases plus randomized
// sequences checked against a byte-level model of the option field.
module tb_tcp_option_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  option_en = '0;
    logic [15:0] mss = '0;
    logic [7:0]  scale_wnd = '0;
    logic [2:0]  sack_nbr = '0;
    logic [63:0] sack_n0 = '0, sack_n1 = '0, sack_n2 = '0, sack_n3 = '0;
    logic [63:0] time_stp = '0;
    logic        data_ready = 1'b1;
    logic [31:0] data;
    logic        data_valid, data_last, busy, done;
    logic [3:0]  opt_words;
    logic [8:0]  option_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic [8:0]  exp_err;

    tcp_option_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .option_en (option_en),
        .mss       (mss),
        .scale_wnd (scale_wnd),
        .sack_nbr  (sack_nbr),
        .sack_n0   (sack_n0),
        .sack_n1   (sack_n1),
        .sack_n2   (sack_n2),
        .sack_n3   (sack_n3),
        .time_stp  (time_stp),
        .data_ready(data_ready),
        .data      (data),
        .data_valid(data_valid),
        .data_last (data_last),
        .busy      (busy),
        .done      (done),
        .opt_words (opt_words),
        .option_err(option_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Reference: build the option field byte by byte, enforce the 40-byte budget, then pack.
    task automatic build_expected();
        logic [7:0]  bq [$];
        logic [63:0] blk [4];
        int n;
        blk[0] = sack_n0; blk[1] = sack_n1; blk[2] = sack_n2; blk[3] = sack_n3;
        bq = {};
        exp_q = {};
        exp_err = option_en & 9'b0_1100_0011;
        if (option_en[2]) begin
            bq.push_back(8'h02); bq.push_back(8'h04);
            bq.push_back(mss[15:8]); bq.push_back(mss[7:0]);
        end
        if (option_en[3]) begin
            bq.push_back(8'h01); bq.push_back(8'h03); bq.push_back(8'h03); bq.push_back(scale_wnd);
        end
        if (option_en[4]) begin
            bq.push_back(8'h01); bq.push_back(8'h01); bq.push_back(8'h04); bq.push_back(8'h02);
        end
        if (option_en[8]) begin
            bq.push_back(8'h01); bq.push_back(8'h01); bq.push_back(8'h08); bq.push_back(8'h0A);
            for (int k = 7; k >= 0; k--) bq.push_back(time_stp[k*8 +: 8]);
        end
        if (option_en[5]) begin
            n = int'(sack_nbr);
            if (n == 0 || n > 4) begin
                exp_err[5] = 1'b1;
                n = 0;
            end else begin
                while (n > 0 && bq.size() + 4 + 8 * n > 40) n--;
                if (n != int'(sack_nbr)) exp_err[5] = 1'b1;
            end
            if (n > 0) begin
                bq.push_back(8'h01); bq.push_back(8'h01); bq.push_back(8'h05);
                bq.push_back(8'(2 + 8 * n));
                for (int b = 0; b < n; b++)
                    for (int k = 7; k >= 0; k--) bq.push_back(blk[b][k*8 +: 8]);
            end
        end
        for (int i = 0; i < bq.size(); i += 4)
            exp_q.push_back({bq[i], bq[i+1], bq[i+2], bq[i+3]});
    endtask

    // One start request and the full observation of the resulting sequence.
    task automatic applyStimulus(input string name, input int stall_pct, input int stall_word, input bit noise);
        int exp_n, acc, done_cyc, last_acc, stall_cnt;
        logic prev_stall, prev_last;
        logic [31:0] prev_data;
        logic [8:0] err_saved;
        build_expected();
        exp_n = exp_q.size();
        err_saved = exp_err;
        acc = 0; done_cyc = -1; last_acc = -1; stall_cnt = 0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        @(negedge clk);
        start = 1'b1;
        data_ready = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                checkOutput({name, ":valid_c1"}, data_valid, 0);
                checkOutput({name, ":busy_c1"}, busy, exp_n != 0);
                checkOutput({name, ":opt_words"}, opt_words, exp_n);
            end
            if (c == 2 && exp_n > 0) checkOutput({name, ":first_valid"}, data_valid, 1);
            if (prev_stall) begin
                checkOutput({name, ":hold_valid"}, data_valid, 1);
                checkOutput({name, ":hold_data"}, data, prev_data);
                checkOutput({name, ":hold_last"}, data_last, prev_last);
                checkOutput({name, ":hold_busy"}, busy, 1);
            end
            if (last_acc > 0 && c == last_acc + 1) begin
                checkOutput({name, ":valid_after_last"}, data_valid, 0);
                checkOutput({name, ":busy_after_last"}, busy, 0);
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (done_cyc > 0 && c == done_cyc + 1) begin
                checkOutput({name, ":done_width"}, done, 0);
                break;
            end
            data_ready = 1'b1;
            if (stall_word >= 0 && acc == stall_word && data_valid && stall_cnt < 3) begin
                data_ready = 1'b0;
                stall_cnt++;
            end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                data_ready = 1'b0;
            end
            prev_stall = 1'b0;
            if (data_valid) begin
                if (acc >= exp_n) begin
                    checkOutput({name, ":extra_word"}, 1, 0);
                end else if (data_ready) begin
                    checkOutput($sformatf("%s:word%0d", name, acc), data, exp_q[acc]);
                    checkOutput($sformatf("%s:last%0d", name, acc), data_last, acc == exp_n - 1);
                    acc++;
                    if (acc == exp_n) last_acc = c;
                end else begin
                    prev_stall = 1'b1;
                    prev_data = data;
                    prev_last = data_last;
                end
            end
            if (noise) begin
                start = (exp_n > 0 && last_acc < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                mss = 16'($urandom);
                time_stp = {$urandom, $urandom};
                option_en = 9'($urandom);
            end
        end
        start = 1'b0;
        data_ready = 1'b1;
        checkOutput({name, ":word_count"}, acc, exp_n);
        checkOutput({name, ":done_cycle"}, done_cyc, (exp_n == 0) ? 2 : last_acc + 2);
        checkOutput({name, ":option_err"}, option_err, err_saved);
        checkOutput({name, ":opt_words_hold"}, opt_words, exp_n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst:data", data, 0);
        checkOutput("rst:valid", data_valid, 0);
        checkOutput("rst:last", data_last, 0);
        checkOutput("rst:busy", busy, 0);
        checkOutput("rst:done", done, 0);
        checkOutput("rst:opt_words", opt_words, 0);
        checkOutput("rst:option_err", option_err, 0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] case 1: MSS only");
        option_en = 9'h004; mss = 16'h05B4;
        applyStimulus("c1", 0, -1, 1'b0);
        checkOutput("c1:word0_const", exp_q[0], 32'h0204_05B4);

        $display("[TB] case 2: MSS WS SACKP TS");
        option_en = 9'h11C; mss = 16'h05B4; scale_wnd = 8'd7; time_stp = 64'h12345678_9ABCDEF0;
        applyStimulus("c2", 0, -1, 1'b0);

        $display("[TB] case 3: TS and SACK trimmed");
        option_en = 9'h120; sack_nbr = 3'd4;
        sack_n0 = 64'h11111111_22222222; sack_n1 = 64'h33333333_44444444;
        sack_n2 = 64'h55555555_66666666; sack_n3 = 64'h77777777_88888888;
        applyStimulus("c3", 0, -1, 1'b0);
        checkOutput("c3:word3_const", exp_q[3], 32'h0101_051A);

        $display("[TB] case 4: stall on word 2");
        option_en = 9'h11C;
        applyStimulus("c4", 0, 2, 1'b0);

        $display("[TB] case 5: empty plans");
        option_en = 9'h000;
        applyStimulus("c5a", 0, -1, 1'b0);
        option_en = 9'h040;
        applyStimulus("c5b", 0, -1, 1'b0);

        $display("[TB] case 6: reset mid-sequence");
        option_en = 9'h11C;
        build_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !(data_valid && data === exp_q[3]); c++) @(negedge clk);
        checkOutput("c6:reach_word3", data_valid && data === exp_q[3], 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("c6:data", data, 0);
        checkOutput("c6:valid", data_valid, 0);
        checkOutput("c6:last", data_last, 0);
        checkOutput("c6:busy", busy, 0);
        checkOutput("c6:done", done, 0);
        checkOutput("c6:opt_words", opt_words, 0);
        checkOutput("c6:option_err", option_err, 0);
        repeat (2) @(negedge clk);
        checkOutput("c6:no_done", done, 0);
        reset = 1'b1;
        applyStimulus("c6_rerun", 0, -1, 1'b0);

        $display("[TB] randomized sequences");
        for (int t = 0; t < 40; t++) begin
            option_en = 9'($urandom);
            if (t % 2 == 1) option_en = option_en & 9'h13C;
            mss = 16'($urandom);
            scale_wnd = 8'($urandom);
            sack_nbr = 3'($urandom);
            sack_n0 = {$urandom, $urandom};
            sack_n1 = {$urandom, $urandom};
            sack_n2 = {$urandom, $urandom};
            sack_n3 = {$urandom, $urandom};
            time_stp = {$urandom, $urandom};
            applyStimulus($sformatf("rnd%0d", t), $urandom_range(0, 60), -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
